// File: rtl/imem_loader.sv
// Byte-serial instruction-memory loader: 32-bit words in, four MSB-first byte writes out.
// Optional running word checksum output under `IMEM_LOADER_CHECKSUM_EN`.
module imem_loader #(
    parameter int ADDR_W      = 9,
    parameter int DEPTH_BYTES = 512,
    parameter int BASE_ADDR   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic              core_hold
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCEPT = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    // One spare address bit so a completely filled store still fails the next check.
    localparam logic [ADDR_W:0]   BASE_EXT = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0]   ONE      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W+1:0] THREE    = (ADDR_W+2)'(3);
    localparam logic [ADDR_W+1:0] LIMIT    = (ADDR_W+2)'(DEPTH_BYTES - 1);

    logic [2:0]      state_q, state_d;
    logic [ADDR_W:0] addr_q, addr_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [31:0]     word_q, word_d;
    logic            last_q, last_d;
    logic            overflow;

    assign overflow = ({1'b0, addr_q} + THREE) > LIMIT;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        last_d     = last_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_ACCEPT;
                    addr_d  = BASE_EXT;
                end
            end
            S_ACCEPT: begin
                if (s_valid) begin
                    word_d     = s_data;
                    last_d     = s_last;
                    byte_idx_d = 2'd0;
                    state_d    = overflow ? S_ERROR : S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d     = addr_q + ONE;
                byte_idx_d = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    state_d = last_q ? S_DONE : S_ACCEPT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= BASE_EXT;
            byte_idx_q <= 2'd0;
            word_q     <= 32'd0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            last_q     <= last_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;
    logic        restart;
    logic        accept_ok;

    assign restart   = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
    assign accept_ok = (state_q == S_ACCEPT) && s_valid && !overflow;

    always_comb begin
        checksum_d = checksum_q;
        if (restart) begin
            checksum_d = 32'd0;
        end else if (accept_ok) begin
            checksum_d = checksum_q + s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= 32'd0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    assign s_ready   = (state_q == S_ACCEPT);
    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = addr_q[ADDR_W-1:0];
    assign busy      = (state_q == S_ACCEPT) || (state_q == S_WRITE);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERROR);
    assign core_hold = (state_q != S_DONE);

    always_comb begin
        mem_wdata = 8'd0;
        if (state_q == S_WRITE) begin
            case (byte_idx_q)
                2'd0:    mem_wdata = word_q[31:24];
                2'd1:    mem_wdata = word_q[23:16];
                2'd2:    mem_wdata = word_q[15:8];
                default: mem_wdata = word_q[7:0];
            endcase
        end
    end

endmodule
